// File: rtl/sub_norm_unit_if.sv
// Valid/ready bus for sub_norm_unit: operand handshake in, normalized result handshake out.
// The o_op_cnt member exists only when SUB_NORM_PERF_CNT_EN is defined.
interface sub_norm_unit_if #(
    parameter int SIZE_SUB   = 28,
    parameter int SIZE_SHIFT = 5
);
    logic                  i_valid;
    logic                  o_ready;
    logic [SIZE_SUB-1:0]   i_data_a;
    logic [SIZE_SUB-1:0]   i_data_b;
    logic                  o_valid;
    logic                  i_ready;
    logic [SIZE_SUB-1:0]   o_diff;
    logic                  o_sign;
    logic [SIZE_SHIFT-1:0] o_shift;
    logic                  o_zero;
`ifdef SUB_NORM_PERF_CNT_EN
    logic [15:0]           o_op_cnt;
`endif

    modport master (
        output i_valid, i_data_a, i_data_b, i_ready,
        input  o_ready, o_valid, o_diff, o_sign, o_shift, o_zero
`ifdef SUB_NORM_PERF_CNT_EN
        , input o_op_cnt
`endif
    );

    modport slave (
        input  i_valid, i_data_a, i_data_b, i_ready,
        output o_ready, o_valid, o_diff, o_sign, o_shift, o_zero
`ifdef SUB_NORM_PERF_CNT_EN
        , output o_op_cnt
`endif
    );
endinterface

// File: rtl/sub_norm_unit.sv
// Two-stage pipelined magnitude subtractor with leading-zero normalization for the FP mantissa path.
// Optional output-transfer counter o_op_cnt enabled by defining SUB_NORM_PERF_CNT_EN.
module sub_norm_unit #(
    parameter int SIZE_SUB   = 28,
    parameter int SIZE_SHIFT = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    sub_norm_unit_if.slave    bus
);

    logic                  s1Valid_q, s1Valid_d;
    logic [SIZE_SUB-1:0]   s1Diff_q,  s1Diff_d;
    logic                  s1Sign_q,  s1Sign_d;
    logic                  s1Zero_q,  s1Zero_d;

    logic                  s2Valid_q, s2Valid_d;
    logic [SIZE_SUB-1:0]   s2Diff_q,  s2Diff_d;
    logic                  s2Sign_q,  s2Sign_d;
    logic [SIZE_SHIFT-1:0] s2Shift_q, s2Shift_d;
    logic                  s2Zero_q,  s2Zero_d;

    logic                  s2Free;
    logic                  inXfer;
    logic                  advance;
    logic                  outXfer;
    logic [SIZE_SUB:0]     subSum;
    logic [SIZE_SHIFT-1:0] lzCount;
    logic                  lzFound;

    assign s2Free  = !s2Valid_q || bus.i_ready;
    assign advance = s1Valid_q && s2Free;
    assign outXfer = s2Valid_q && bus.i_ready;
    assign inXfer  = bus.i_valid && bus.o_ready;

    assign bus.o_ready = !s1Valid_q || s2Free;
    assign bus.o_valid = s2Valid_q;
    assign bus.o_diff  = s2Diff_q;
    assign bus.o_sign  = s2Sign_q;
    assign bus.o_shift = s2Shift_q;
    assign bus.o_zero  = s2Zero_q;

    // A one-bit-wider two's-complement subtract; the carry out tells us a >= b.
    assign subSum = {1'b0, bus.i_data_a} + {1'b0, ~bus.i_data_b} + {{SIZE_SUB{1'b0}}, 1'b1};

    always_comb begin
        s1Valid_d = s1Valid_q;
        s1Diff_d  = s1Diff_q;
        s1Sign_d  = s1Sign_q;
        s1Zero_d  = s1Zero_q;
        if (inXfer) begin
            s1Valid_d = 1'b1;
            s1Zero_d  = (bus.i_data_a == bus.i_data_b);
            if (subSum[SIZE_SUB]) begin
                s1Diff_d = subSum[SIZE_SUB-1:0];
                s1Sign_d = 1'b0;
            end else begin
                s1Diff_d = bus.i_data_b - bus.i_data_a;
                s1Sign_d = 1'b1;
            end
        end else if (advance) begin
            s1Valid_d = 1'b0;
        end
    end

    always_comb begin
        lzCount = '0;
        lzFound = 1'b0;
        for (int i = SIZE_SUB - 1; i >= 0; i--) begin
            if (!lzFound) begin
                if (s1Diff_q[i]) begin
                    lzFound = 1'b1;
                end else begin
                    lzCount = lzCount + SIZE_SHIFT'(1);
                end
            end
        end
    end

    // An equal-operand result is forced to +0 with no shift so it is never reported negative.
    always_comb begin
        s2Valid_d = s2Valid_q;
        s2Diff_d  = s2Diff_q;
        s2Sign_d  = s2Sign_q;
        s2Shift_d = s2Shift_q;
        s2Zero_d  = s2Zero_q;
        if (advance) begin
            s2Valid_d = 1'b1;
            s2Zero_d  = s1Zero_q;
            if (s1Zero_q) begin
                s2Diff_d  = '0;
                s2Shift_d = '0;
                s2Sign_d  = 1'b0;
            end else begin
                s2Diff_d  = s1Diff_q << lzCount;
                s2Shift_d = lzCount;
                s2Sign_d  = s1Sign_q;
            end
        end else if (outXfer) begin
            s2Valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1Valid_q <= 1'b0;
            s1Diff_q  <= '0;
            s1Sign_q  <= 1'b0;
            s1Zero_q  <= 1'b0;
            s2Valid_q <= 1'b0;
            s2Diff_q  <= '0;
            s2Sign_q  <= 1'b0;
            s2Shift_q <= '0;
            s2Zero_q  <= 1'b0;
        end else begin
            s1Valid_q <= s1Valid_d;
            s1Diff_q  <= s1Diff_d;
            s1Sign_q  <= s1Sign_d;
            s1Zero_q  <= s1Zero_d;
            s2Valid_q <= s2Valid_d;
            s2Diff_q  <= s2Diff_d;
            s2Sign_q  <= s2Sign_d;
            s2Shift_q <= s2Shift_d;
            s2Zero_q  <= s2Zero_d;
        end
    end

`ifdef SUB_NORM_PERF_CNT_EN
    logic [15:0] opCnt_q, opCnt_d;

    assign opCnt_d      = outXfer ? opCnt_q + 16'd1 : opCnt_q;
    assign bus.o_op_cnt = opCnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            opCnt_q <= '0;
        end else begin
            opCnt_q <= opCnt_d;
        end
    end
`endif

endmodule
